// File: rtl/entropy_word_packer.sv
// Raw oscillator bit consumer: repetition-count health test, optional von Neumann
// debias, and packing into WORD_W-bit words behind a valid/ready output register.
module entropy_word_packer #(
  parameter int WORD_W     = 64,
  parameter int RCT_CUTOFF = 32,
  parameter int RCT_W      = 6
) (
  input  logic                       clk,
  input  logic                       E,
  input  logic                       raw_bit,
  input  logic                       raw_valid,
  input  logic                       vn_en,
  output logic [WORD_W-1:0]          word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       health_fail,
  output logic                       overrun,
  output logic [$clog2(WORD_W+1)-1:0] bits_pending
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0]    FULL    = CW'(WORD_W);
  localparam logic [CW-1:0]    LAST    = CW'(WORD_W - 1);
  localparam logic [RCT_W-1:0] CUTOFF  = RCT_W'(RCT_CUTOFF);
  localparam logic [RCT_W-1:0] RUN_MAX = '1;

  logic [WORD_W-1:0] pack;
  logic [RCT_W-1:0]  run;
  logic              last_bit;
  logic              seen;
  logic              vn_phase;
  logic              vn_first;

  logic [RCT_W-1:0]  run_next;
  logic              rct_trip;
  logic              emit;
  logic              emit_bit;
  logic              handshake;
  logic              out_free;
  logic              completing;
  logic [WORD_W-1:0] full_word;

  always_comb begin
    run_next = RCT_W'(1);
    if (seen && (raw_bit == last_bit))
      run_next = (run == RUN_MAX) ? run : run + RCT_W'(1);
    rct_trip = raw_valid && (run_next >= CUTOFF);

    // Pair 10 yields 1 and 01 yields 0, so the emitted bit is the stored first bit.
    emit     = 1'b0;
    emit_bit = raw_bit;
    if (raw_valid) begin
      if (!vn_en) begin
        emit = 1'b1;
      end else if (vn_phase && (vn_first != raw_bit)) begin
        emit     = 1'b1;
        emit_bit = vn_first;
      end
    end

    handshake  = word_valid & word_ready;
    out_free   = !word_valid | handshake;
    completing = emit && (bits_pending == LAST);
    full_word  = pack | (WORD_W'(emit_bit) << bits_pending);
  end

  always_ff @(posedge clk) begin
    if (E) begin
      word_out     <= '0;
      word_valid   <= 1'b0;
      health_fail  <= 1'b0;
      overrun      <= 1'b0;
      bits_pending <= '0;
      pack         <= '0;
      run          <= '0;
      last_bit     <= 1'b0;
      seen         <= 1'b0;
      vn_phase     <= 1'b0;
      vn_first     <= 1'b0;
    end else if (!health_fail) begin
      if (raw_valid) begin
        seen     <= 1'b1;
        last_bit <= raw_bit;
        run      <= run_next;
        vn_phase <= ~vn_phase;
        if (!vn_phase) vn_first <= raw_bit;
      end

      // A failure discards everything in flight, including a word completing now.
      if (rct_trip) begin
        health_fail  <= 1'b1;
        pack         <= '0;
        bits_pending <= '0;
        word_valid   <= 1'b0;
        vn_phase     <= 1'b0;
      end else begin
        if (handshake) word_valid <= 1'b0;

        if (bits_pending == FULL) begin
          if (emit) overrun <= 1'b1;
          if (out_free) begin
            word_out     <= pack;
            word_valid   <= 1'b1;
            pack         <= '0;
            bits_pending <= '0;
          end
        end else if (emit) begin
          if (completing && out_free) begin
            word_out     <= full_word;
            word_valid   <= 1'b1;
            pack         <= '0;
            bits_pending <= '0;
          end else begin
            pack         <= full_word;
            bits_pending <= bits_pending + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_entropy_word_packer.sv
// Directed bench for entropy_word_packer: a per-cycle vector table for pairing and
// counting, then hand-written sequences for words, health failure, backpressure and reset.
module tb_entropy_word_packer;

  logic        clk = 1'b0;
  logic        E = 1'b1;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        vn_en = 1'b0;
  logic [63:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        health_fail;
  logic        overrun;
  logic [6:0]  bits_pending;

  int n_total = 0;
  int n_pass  = 0;

  entropy_word_packer #(.WORD_W(64), .RCT_CUTOFF(32), .RCT_W(6)) dut (
    .clk(clk), .E(E), .raw_bit(raw_bit), .raw_valid(raw_valid), .vn_en(vn_en),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .health_fail(health_fail), .overrun(overrun), .bits_pending(bits_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       e;
    logic       rv;
    logic       rb;
    logic       vn;
    logic       rdy;
    logic [6:0] exp_pend;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic b);
    raw_valid = 1'b1;
    raw_bit   = b;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic do_reset();
    E = 1'b1;
    tick();
    E = 1'b0;
  endtask

  int    nwords;
  logic  seen_valid;
  logic  valid_dropped;
  logic [63:0] cap;
  logic [7:0]  rep_pat;
  logic [3:0]  nib_pat;

  initial begin
    // Pair decoding with vn_en=1: 10 -> 1, 01 -> 0, 00/11 -> nothing; word_ready idle.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd2, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7'd2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 7'd3, 1'b0};

    tick();
    for (int i = 0; i < 13; i++) begin
      E = tbl[i].e; raw_valid = tbl[i].rv; raw_bit = tbl[i].rb;
      vn_en = tbl[i].vn; word_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d pending", i), 64'(bits_pending), 64'(tbl[i].exp_pend));
      chk($sformatf("tbl%0d valid", i), 64'(word_valid), 64'(tbl[i].exp_valid));
    end
    raw_valid = 1'b0; word_ready = 1'b0;

    // Plain word, alternating bits starting with 1.
    vn_en = 1'b0;
    do_reset();
    chk("rst word_out", word_out, 64'h0);
    chk("rst valid", 64'(word_valid), 64'h0);
    chk("rst pending", 64'(bits_pending), 64'h0);
    chk("rst fail", 64'(health_fail), 64'h0);
    chk("rst overrun", 64'(overrun), 64'h0);
    word_ready = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 63; i++) begin
      send((i % 2) == 0);
      if (word_valid) seen_valid = 1'b1;
    end
    chk("w1 early valid", 64'(seen_valid), 64'h0);
    chk("w1 pending63", 64'(bits_pending), 64'd63);
    send(1'b0);
    chk("w1 valid", 64'(word_valid), 64'h1);
    chk("w1 word", word_out, 64'h5555555555555555);
    chk("w1 pending", 64'(bits_pending), 64'h0);
    chk("w1 fail", 64'(health_fail), 64'h0);
    chk("w1 overrun", 64'(overrun), 64'h0);
    tick();
    chk("w1 one cycle", 64'(word_valid), 64'h0);

    // Debiased word: 1,0,0,1,1,1,0,0 yields bits 1,0 per repetition.
    E = 1'b1; vn_en = 1'b1; tick(); E = 1'b0;
    rep_pat = 8'b0011_1001;
    nwords = 0; cap = '0;
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < 8; k++) begin
        send(rep_pat[k]);
        if (word_valid) begin nwords++; cap = word_out; end
      end
      if (r == 15) chk("vn pending32", 64'(bits_pending), 64'd32);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (word_valid) nwords++;
    end
    chk("vn word count", 64'(nwords), 64'd1);
    chk("vn word", cap, 64'h5555555555555555);

    // Repetition count: 31 ones pass, 32 ones trip, even as the word completes.
    E = 1'b1; vn_en = 1'b0; tick(); E = 1'b0;
    for (int i = 0; i < 31; i++) send(1'b1);
    send(1'b0);
    chk("rct31 fail", 64'(health_fail), 64'h0);
    for (int i = 0; i < 31; i++) send(1'b1);
    chk("rct63 fail", 64'(health_fail), 64'h0);
    chk("rct63 pending", 64'(bits_pending), 64'd63);
    send(1'b1);
    chk("rct32 fail", 64'(health_fail), 64'h1);
    chk("rct32 pending", 64'(bits_pending), 64'h0);
    chk("rct32 valid", 64'(word_valid), 64'h0);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(i[0]);
      if (word_valid || bits_pending != 7'd0) seen_valid = 1'b1;
    end
    chk("rct ignore", 64'(seen_valid), 64'h0);
    chk("rct sticky", 64'(health_fail), 64'h1);
    do_reset();
    chk("rct cleared", 64'(health_fail), 64'h0);

    // Backpressure: word 1 in output, word 2 held, extra bit overruns.
    word_ready = 1'b0;
    for (int i = 0; i < 64; i++) send((i % 2) == 0);
    nib_pat = 4'b0011;
    for (int i = 0; i < 64; i++) send(nib_pat[i % 4]);
    chk("bp valid", 64'(word_valid), 64'h1);
    chk("bp word1", word_out, 64'h5555555555555555);
    chk("bp pending", 64'(bits_pending), 64'd64);
    chk("bp overrun0", 64'(overrun), 64'h0);
    send(1'b1);
    chk("bp overrun1", 64'(overrun), 64'h1);
    chk("bp pending held", 64'(bits_pending), 64'd64);
    word_ready = 1'b1; tick(); word_ready = 1'b0;
    chk("bp word2", word_out, 64'h3333333333333333);
    chk("bp valid kept", 64'(word_valid), 64'h1);
    chk("bp pending0", 64'(bits_pending), 64'h0);
    tick();
    chk("bp stable", word_out, 64'h3333333333333333);

    // Handshake coinciding with completion of the next word.
    valid_dropped = 1'b0;
    for (int i = 0; i < 63; i++) begin
      send((i % 2) == 1);
      if (!word_valid) valid_dropped = 1'b1;
    end
    chk("hs held word2", word_out, 64'h3333333333333333);
    word_ready = 1'b1;
    send(1'b1);
    word_ready = 1'b0;
    if (!word_valid) valid_dropped = 1'b1;
    chk("hs no gap", 64'(valid_dropped), 64'h0);
    chk("hs word3", word_out, 64'hAAAAAAAAAAAAAAAA);
    chk("hs pending", 64'(bits_pending), 64'h0);

    // Reset mid-word with a pending output word, then a fresh aligned word.
    for (int i = 0; i < 20; i++) send((i % 2) == 0);
    chk("mid pending20", 64'(bits_pending), 64'd20);
    chk("mid valid", 64'(word_valid), 64'h1);
    do_reset();
    chk("mid rst word", word_out, 64'h0);
    chk("mid rst valid", 64'(word_valid), 64'h0);
    chk("mid rst pending", 64'(bits_pending), 64'h0);
    chk("mid rst overrun", 64'(overrun), 64'h0);
    word_ready = 1'b1;
    nwords = 0; cap = '0;
    for (int i = 0; i < 64; i++) begin
      send(((i / 4) % 2) == 0);
      if (word_valid) begin nwords++; cap = word_out; end
    end
    tick();
    if (word_valid) nwords++;
    chk("fresh count", 64'(nwords), 64'd1);
    chk("fresh word", cap, 64'h0F0F0F0F0F0F0F0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
